// File: rtl/jtag_ni_dma_ctrl_if.sv
// Wishbone master bundle between the JTAG DMA controller and the NI register banks.
interface jtag_ni_dma_ctrl_if #(
   parameter int unsigned Dw   = 32,
   parameter int unsigned M_Aw = 32,
   parameter int unsigned TAGw = 3,
   parameter int unsigned SELw = 4
);
   logic [SELw-1:0] m_sel_o;
   logic [Dw-1:0]   m_dat_o;
   logic [M_Aw-1:0] m_addr_o;
   logic [TAGw-1:0] m_tag_o;
   logic            m_stb_o;
   logic            m_cyc_o;
   logic            m_we_o;
   logic [Dw-1:0]   m_dat_i;
   logic            m_ack_i;
   logic            m_err_i;
   logic            m_rty_i;

   modport master (
      output m_sel_o, m_dat_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
      input  m_dat_i, m_ack_i, m_err_i, m_rty_i
   );

   modport slave (
      input  m_sel_o, m_dat_o, m_addr_o, m_tag_o, m_stb_o, m_cyc_o, m_we_o,
      output m_dat_i, m_ack_i, m_err_i, m_rty_i
   );
endinterface

// File: rtl/jtag_ni_dma_ctrl.sv
// JTAG-to-NI DMA sequencer: programs an NI channel over Wishbone, then polls its status to completion.
// Optional macro JTAG_DMA_TIMEOUT_EN bounds polling (err_code 2'b11 after 1024 busy polls).
module jtag_ni_dma_ctrl #(
   parameter logic [31:0] NI_BASE_ADDR   = 32'h0,
   parameter int unsigned NI_CH_STRIDE   = 8,
   parameter logic [31:0] JTAG_BASE_ADDR = 32'h0,
   parameter int unsigned CHANNELS       = 2,
   parameter int unsigned PCKw           = 8,
   parameter int unsigned POLL_WAIT      = 8,
   parameter int unsigned MAX_RTY        = 3,
   parameter int unsigned Dw             = 32,
   parameter int unsigned M_Aw           = 32,
   parameter int unsigned TAGw           = 3,
   parameter int unsigned SELw           = 4,
   localparam int unsigned CHw = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_start,
   input  logic               cmd_dir,
   input  logic [CHw-1:0]     cmd_ch,
   input  logic [PCKw-1:0]    cmd_pck_size,
   jtag_ni_dma_ctrl_if.master wb,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);
   typedef enum logic [2:0] {IDLE, WR_SIZE, WR_PTR, WAIT, POLL, ERR} state_t;

   state_t          r_state, w_state_nxt;
   logic            r_start_d, w_accept;
   logic            r_dir, w_dir_nxt;
   logic [CHw-1:0]  r_ch, w_ch_nxt;
   logic [PCKw-1:0] r_size, w_size_nxt;
   logic [7:0]      r_wait_cnt, w_wait_nxt;
   logic [7:0]      r_rty_cnt, w_rty_nxt;
   logic            r_gap, w_gap_nxt;
   logic            r_done, w_done_nxt;
   logic            r_err, w_err_nxt;
   logic [1:0]      r_err_code, w_code_nxt;
`ifdef JTAG_DMA_TIMEOUT_EN
   logic [15:0]     r_poll_cnt, w_poll_nxt;
`endif
   logic            w_stb, w_we;
   logic [M_Aw-1:0] w_base, w_addr;
   logic [Dw-1:0]   w_wdat;
   logic [PCKw:0]   w_size_p1;

   assign w_accept  = r_start_d & ~cmd_start;
   assign w_base    = M_Aw'(NI_BASE_ADDR) + M_Aw'(r_ch) * M_Aw'(NI_CH_STRIDE);
   assign w_size_p1 = {1'b0, r_size} + (PCKw+1)'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_ch_nxt    = r_ch;
      w_size_nxt  = r_size;
      w_wait_nxt  = r_wait_cnt;
      w_rty_nxt   = r_rty_cnt;
      w_gap_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_code_nxt  = r_err_code;
`ifdef JTAG_DMA_TIMEOUT_EN
      w_poll_nxt  = r_poll_cnt;
`endif
      w_stb  = 1'b0;
      w_we   = 1'b0;
      w_addr = '0;
      w_wdat = '0;
      case (r_state)
         IDLE: if (w_accept) begin
            w_dir_nxt  = cmd_dir;
            w_ch_nxt   = cmd_ch;
            w_size_nxt = cmd_pck_size;
            w_err_nxt  = 1'b0;
            w_code_nxt = 2'b00;
            w_rty_nxt  = '0;
`ifdef JTAG_DMA_TIMEOUT_EN
            w_poll_nxt = '0;
`endif
            if (32'(cmd_ch) >= CHANNELS) begin
               w_state_nxt = ERR;
               w_err_nxt   = 1'b1;
               w_code_nxt  = 2'b01;
            end else begin
               w_state_nxt = WR_SIZE;
            end
         end
         WR_SIZE: begin
            w_stb  = ~r_gap;
            w_we   = 1'b1;
            w_addr = w_base + M_Aw'(3);
            w_wdat = Dw'(w_size_p1);
         end
         WR_PTR: begin
            w_stb  = ~r_gap;
            w_we   = 1'b1;
            w_addr = w_base + (r_dir ? M_Aw'(4) : M_Aw'(5));
            w_wdat = Dw'(JTAG_BASE_ADDR << 2);
         end
         WAIT: begin
            if (r_wait_cnt == '0) w_state_nxt = POLL;
            else                  w_wait_nxt  = r_wait_cnt - 8'd1;
         end
         POLL: begin
            w_stb  = ~r_gap;
            w_addr = w_base;
         end
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      // Responses only count while strobing; err outranks ack, ack outranks rty.
      if (w_stb) begin
         if (wb.m_err_i) begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
            w_code_nxt  = 2'b01;
         end else if (wb.m_ack_i) begin
            w_rty_nxt = '0;
            case (r_state)
               WR_SIZE: w_state_nxt = WR_PTR;
               WR_PTR: begin
                  w_state_nxt = WAIT;
                  w_wait_nxt  = 8'(POLL_WAIT - 1);
               end
               POLL: begin
                  if (wb.m_dat_i[0]) begin
                     w_state_nxt = WAIT;
                     w_wait_nxt  = 8'(POLL_WAIT - 1);
`ifdef JTAG_DMA_TIMEOUT_EN
                     w_poll_nxt  = r_poll_cnt + 16'd1;
                     if (r_poll_cnt >= 16'd1024) begin
                        w_state_nxt = ERR;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = 2'b11;
                     end
`endif
                  end else begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = IDLE;
                  end
               end
               default: ;
            endcase
         end else if (wb.m_rty_i) begin
            if (32'(r_rty_cnt) >= MAX_RTY) begin
               w_state_nxt = ERR;
               w_err_nxt   = 1'b1;
               w_code_nxt  = 2'b10;
            end else begin
               w_rty_nxt = r_rty_cnt + 8'd1;
               w_gap_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_start_d  <= 1'b0;
         r_dir      <= 1'b0;
         r_ch       <= '0;
         r_size     <= '0;
         r_wait_cnt <= '0;
         r_rty_cnt  <= '0;
         r_gap      <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
`ifdef JTAG_DMA_TIMEOUT_EN
         r_poll_cnt <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_start_d  <= cmd_start;
         r_dir      <= w_dir_nxt;
         r_ch       <= w_ch_nxt;
         r_size     <= w_size_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_rty_cnt  <= w_rty_nxt;
         r_gap      <= w_gap_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         r_err_code <= w_code_nxt;
`ifdef JTAG_DMA_TIMEOUT_EN
         r_poll_cnt <= w_poll_nxt;
`endif
      end
   end

   assign wb.m_stb_o  = w_stb;
   assign wb.m_cyc_o  = w_stb;
   assign wb.m_we_o   = w_stb & w_we;
   assign wb.m_dat_o  = (w_stb & w_we) ? w_wdat : '0;
   assign wb.m_addr_o = w_addr;
   assign wb.m_sel_o  = '1;
   assign wb.m_tag_o  = '0;

   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign err      = r_err;
   assign err_code = r_err_code;
endmodule

// File: tb/tb_jtag_ni_dma_ctrl.sv
// Directed bench for jtag_ni_dma_ctrl with a combinational Wishbone slave and access log.
module tb_jtag_ni_dma_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_start = 1'b0;
   logic       cmd_dir = 1'b0;
   logic [1:0] cmd_ch = 2'd0;
   logic [7:0] cmd_pck_size = 8'd0;
   logic       busy, done, err;
   logic [1:0] err_code;

   jtag_ni_dma_ctrl_if #(.Dw(32), .M_Aw(32), .TAGw(3), .SELw(4)) wb ();

   jtag_ni_dma_ctrl #(
      .NI_BASE_ADDR(32'h100), .NI_CH_STRIDE(8), .JTAG_BASE_ADDR(32'h40),
      .CHANNELS(3), .PCKw(8), .POLL_WAIT(4), .MAX_RTY(3),
      .Dw(32), .M_Aw(32), .TAGw(3), .SELw(4)
   ) dut (
      .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_dir(cmd_dir),
      .cmd_ch(cmd_ch), .cmd_pck_size(cmd_pck_size), .wb(wb),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, wr_cnt = 0, rd_cnt = 0, rty_total = 0, done_cnt = 0, stb_cnt = 0;
   int gap_bad = 0, sel_bad = 0, dat_bad = 0;
   int busy_limit = 0, rty_limit = 0;
   logic        err_en = 1'b0, hold_rd = 1'b0, prev_rty = 1'b0;
   logic [31:0] err_addr = 32'd0, rd_addr_last = 32'd0;
   logic [31:0] wr_addr [0:63];
   logic [31:0] wr_dat  [0:63];
   int          rd_cyc  [0:4095];
   logic        s_ack, s_err, s_rty;
   logic [31:0] s_dat;

   always_comb begin
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = 32'd0;
      if (wb.m_stb_o && wb.m_cyc_o) begin
         if (rty_total < rty_limit) s_rty = 1'b1;
         else if (!(hold_rd && !wb.m_we_o)) begin
            s_ack = 1'b1;
            if (err_en && wb.m_we_o && wb.m_addr_o == err_addr) s_err = 1'b1;
            if (!wb.m_we_o) s_dat = {31'd0, (rd_cnt < busy_limit)};
         end
      end
   end
   assign wb.m_ack_i = s_ack;
   assign wb.m_err_i = s_err;
   assign wb.m_rty_i = s_rty;
   assign wb.m_dat_i = s_dat;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (wb.m_sel_o !== 4'hF || wb.m_tag_o !== 3'd0) sel_bad <= sel_bad + 1;
      if (!(wb.m_stb_o && wb.m_we_o) && wb.m_dat_o !== 32'd0) dat_bad <= dat_bad + 1;
      if (prev_rty && wb.m_stb_o) gap_bad <= gap_bad + 1;
      prev_rty <= wb.m_stb_o && s_rty && !s_err;
      if (wb.m_stb_o) begin
         stb_cnt <= stb_cnt + 1;
         if (s_rty) rty_total <= rty_total + 1;
         else if (s_ack && !s_err) begin
            if (wb.m_we_o) begin
               wr_addr[wr_cnt] <= wb.m_addr_o;
               wr_dat[wr_cnt]  <= wb.m_dat_o;
               wr_cnt <= wr_cnt + 1;
            end else begin
               rd_addr_last <= wb.m_addr_o;
               rd_cyc[rd_cnt] <= cyc;
               rd_cnt <= rd_cnt + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic d, input logic [1:0] ch, input logic [7:0] sz);
      @(negedge clk);
      cmd_dir = d; cmd_ch = ch; cmd_pck_size = sz; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int max, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (!busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic ok;
      int w0, r0, d0, t0, s0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_stb", wb.m_stb_o, 0);
      chk("rst_cyc", wb.m_cyc_o, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // ch1, dir0, size5, two busy polls
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; busy_limit = rd_cnt + 2;
      start_cmd(1'b0, 2'd1, 8'd5);
      chk("t1_busy", busy, 1);
      wait_idle(200, ok);
      chk("t1_idle", ok, 1);
      chk("t1_size_addr", wr_addr[w0], 32'h10B);
      chk("t1_size_dat", wr_dat[w0], 32'd6);
      chk("t1_ptr_addr", wr_addr[w0+1], 32'h10D);
      chk("t1_ptr_dat", wr_dat[w0+1], 32'h100);
      chk("t1_writes", wr_cnt - w0, 2);
      chk("t1_reads", rd_cnt - r0, 3);
      chk("t1_poll_addr", rd_addr_last, 32'h108);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_err", err, 0);

      // ch0, dir1, three busy polls; a start pulse mid-transfer must be ignored
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; busy_limit = rd_cnt + 3;
      start_cmd(1'b1, 2'd0, 8'd0);
      repeat (3) @(negedge clk);
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      wait_idle(300, ok);
      chk("t2_idle", ok, 1);
      chk("t2_size_addr", wr_addr[w0], 32'h103);
      chk("t2_size_dat", wr_dat[w0], 32'd1);
      chk("t2_ptr_addr", wr_addr[w0+1], 32'h104);
      chk("t2_reads", rd_cnt - r0, 4);
      chk("t2_poll_addr", rd_addr_last, 32'h100);
      chk("t2_space0", rd_cyc[r0+1] - rd_cyc[r0], 5);
      chk("t2_space2", rd_cyc[r0+3] - rd_cyc[r0+2], 5);
      repeat (5) @(negedge clk);
      chk("t2_no_restart", busy, 0);
      chk("t2_writes", wr_cnt - w0, 2);
      chk("t2_done", done_cnt - d0, 1);

      // three retries on WR_SIZE, then success
      w0 = wr_cnt; d0 = done_cnt; t0 = rty_total;
      rty_limit = rty_total + 3; busy_limit = rd_cnt;
      start_cmd(1'b0, 2'd0, 8'd2);
      wait_idle(200, ok);
      chk("t3_idle", ok, 1);
      chk("t3_rty", rty_total - t0, 3);
      chk("t3_size_dat", wr_dat[w0], 32'd3);
      chk("t3_done", done_cnt - d0, 1);
      chk("t3_err", err, 0);

      // four retries exhaust the budget
      w0 = wr_cnt; d0 = done_cnt; t0 = rty_total;
      rty_limit = rty_total + 4;
      start_cmd(1'b0, 2'd0, 8'd2);
      wait_idle(200, ok);
      chk("t3b_idle", ok, 1);
      chk("t3b_err", err, 1);
      chk("t3b_code", err_code, 2'b10);
      chk("t3b_busy", busy, 0);
      chk("t3b_rty", rty_total - t0, 4);
      chk("t3b_writes", wr_cnt - w0, 0);
      chk("t3b_done", done_cnt - d0, 0);

      // bus error together with ack on WR_PTR
      w0 = wr_cnt; d0 = done_cnt; err_en = 1'b1; err_addr = 32'h105;
      start_cmd(1'b0, 2'd0, 8'd1);
      wait_idle(200, ok);
      chk("t4_err", err, 1);
      chk("t4_code", err_code, 2'b01);
      chk("t4_done", done_cnt - d0, 0);
      chk("t4_writes", wr_cnt - w0, 1);
      err_en = 1'b0; busy_limit = rd_cnt; d0 = done_cnt;
      start_cmd(1'b0, 2'd0, 8'd1);
      chk("t4_err_clr", err, 0);
      chk("t4_code_clr", err_code, 2'b00);
      wait_idle(200, ok);
      chk("t4_redo_done", done_cnt - d0, 1);

      // out-of-range channel
      s0 = stb_cnt; d0 = done_cnt;
      start_cmd(1'b0, 2'd3, 8'd1);
      wait_idle(20, ok);
      chk("t5_idle", ok, 1);
      chk("t5_err", err, 1);
      chk("t5_code", err_code, 2'b01);
      chk("t5_no_bus", stb_cnt - s0, 0);
      chk("t5_done", done_cnt - d0, 0);

      // reset mid-POLL with cmd_start held high across reset
      hold_rd = 1'b1; busy_limit = rd_cnt + 100;
      start_cmd(1'b0, 2'd1, 8'd2);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (wb.m_stb_o && !wb.m_we_o) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("t6_in_poll", ok, 1);
      cmd_start = 1'b1;
      reset = 1'b0;
      #1;
      chk("t6_stb", wb.m_stb_o, 0);
      chk("t6_cyc", wb.m_cyc_o, 0);
      chk("t6_busy", busy, 0);
      repeat (2) @(negedge clk);
      hold_rd = 1'b0; busy_limit = rd_cnt;
      reset = 1'b1;
      s0 = stb_cnt; d0 = done_cnt;
      repeat (10) @(negedge clk);
      chk("t6_held_busy", busy, 0);
      chk("t6_held_bus", stb_cnt - s0, 0);
      cmd_start = 1'b0;
      @(negedge clk);
      chk("t6_fall_accept", busy, 1);
      wait_idle(200, ok);
      chk("t6_done", done_cnt - d0, 1);

      // status stuck busy
      r0 = rd_cnt; d0 = done_cnt; busy_limit = 32'h7fffffff;
      start_cmd(1'b0, 2'd1, 8'd0);
`ifdef JTAG_DMA_TIMEOUT_EN
      wait_idle(8000, ok);
      chk("t7_idle", ok, 1);
      chk("t7_err", err, 1);
      chk("t7_code", err_code, 2'b11);
      chk("t7_reads", rd_cnt - r0, 1025);
      chk("t7_done", done_cnt - d0, 0);
`else
      ok = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         if (rd_cnt - r0 >= 1030) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("t7_polling", ok, 1);
      chk("t7_busy", busy, 1);
      chk("t7_err", err, 0);
      busy_limit = rd_cnt;
      wait_idle(100, ok);
      chk("t7_idle", ok, 1);
      chk("t7_done", done_cnt - d0, 1);
      chk("t7_err_end", err, 0);
`endif

      chk("gap_after_rty", gap_bad, 0);
      chk("sel_tag_const", sel_bad, 0);
      chk("dat_zero_idle", dat_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtag_ni_dma_ctrl.md
JTAG_NI_DMA_CTRL -- requirements
Module: jtag_ni_dma_ctrl

Interface
REQ-001 SHALL have parameter NI_BASE_ADDR, default 32'h0, word address of NI channel 0 register bank.
REQ-002 SHALL have parameter NI_CH_STRIDE, default 8, word-address stride between NI channel banks.
REQ-003 SHALL have parameter JTAG_BASE_ADDR, default 32'h0, word address of the JTAG packet buffer.
REQ-004 SHALL have parameter CHANNELS, default 2, number of NI channels, legal range 1..8.
REQ-005 SHALL have parameter PCKw, default 8, packet-size field width.
REQ-006 SHALL have parameter POLL_WAIT, default 8, idle cycles between status polls, legal range 1..255.
REQ-007 SHALL have parameter MAX_RTY, default 3, retries allowed per bus cycle.
REQ-008 SHALL have parameters Dw=32, M_Aw=32, TAGw=3, SELw=4, the Wishbone widths.
REQ-009 SHALL have ports: clk in 1 system clock; reset in 1 asynchronous active-low reset.
REQ-010 SHALL have ports: cmd_start in 1 command level; cmd_dir in 1 (0=send to NoC, 1=receive); cmd_ch in clog2(CHANNELS) (min 1) channel index; cmd_pck_size in PCKw payload flits.
REQ-011 SHALL have ports: m_sel_o out SELw; m_dat_o out Dw; m_addr_o out M_Aw; m_tag_o out TAGw; m_stb_o, m_cyc_o, m_we_o out 1; m_dat_i in Dw; m_ack_i, m_err_i, m_rty_i in 1.
REQ-012 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky); err_code out 2.

Function
REQ-013 SHALL detect the falling edge of cmd_start via one register stage; the accept pulse occurs one cycle after the 1->0 transition.
REQ-014 SHALL accept an accept pulse only in IDLE, latch cmd_dir/cmd_ch/cmd_pck_size, clear err/err_code, and move to WR_SIZE; an accept pulse outside IDLE SHALL be ignored.
REQ-015 SHALL use states IDLE, WR_SIZE, WR_PTR, WAIT, POLL, ERR; busy=0 only in IDLE.
REQ-016 SHALL compute channel base as NI_BASE_ADDR + ch*NI_CH_STRIDE in M_Aw bits; register offsets: status +0, read-pointer +4, write-pointer +5, size +3.
REQ-017 WR_SIZE SHALL drive stb=cyc=we=1, addr=base+3, dat=zero-extended (cmd_pck_size+1) computed in PCKw+1 bits; on ack, go to WR_PTR.
REQ-018 WR_PTR SHALL drive a write with dat=JTAG_BASE_ADDR<<2 (truncated to Dw) to base+5 if dir=0, else base+4; on ack, go to WAIT.
REQ-019 WAIT SHALL hold for exactly POLL_WAIT cycles, with all strobes low, then go to POLL.
REQ-020 POLL SHALL read base+0 with we=0; on ack, if m_dat_i[0]=1, go to WAIT; otherwise pulse done for one cycle and go to IDLE.
REQ-021 m_sel_o SHALL be all ones and m_tag_o zero in every state; m_dat_o SHALL be zero when not writing.
REQ-022 m_err_i in any bus state SHALL take priority over ack, send the FSM to ERR with err_code=01.
REQ-023 m_rty_i without err SHALL drop stb/cyc for one cycle, increment the retry count, and reissue the same access; MAX_RTY+1 consecutive retries SHALL go to ERR with err_code=10; the retry count SHALL clear on each ack.
REQ-024 ERR SHALL set err=1 and hold err_code, drive all strobes low, and return to IDLE next cycle without a done pulse.
REQ-025 A cmd_ch value >= CHANNELS SHALL be rejected at accept: ERR with err_code=01 and no bus cycle.

Reset
REQ-026 reset low SHALL asynchronously force IDLE, set all counters, edge register, err, err_code and done to 0, and drop all strobes, including mid-cycle.
REQ-027 After reset deassertion, a cmd_start that is held at 1 SHALL NOT generate an accept until it falls.

Configuration
REQ-028 Macro JTAG_DMA_TIMEOUT_EN: when defined, a 16-bit poll counter cleared at accept SHALL force ERR with err_code=11 when a POLL ack returns busy after the 1024th poll; when undefined, polling SHALL be unbounded and err_code 11 SHALL never occur.

Verification
REQ-029 Scenario: ch=1, NI_BASE_ADDR=0x100, stride 8, size 5, dir 0 -> write 6 to 0x10B, write JTAG_BASE_ADDR<<2 to 0x10D, poll 0x108 until bit0=0, then one done pulse.
REQ-030 Scenario: dir=1, ch=0 -> second write targets 0x104; with status busy for 3 polls, exactly 4 reads occur, spaced POLL_WAIT+ cycles apart.
REQ-031 Scenario: m_rty_i on the first 3 tries of WR_SIZE -> 3 reissues, success on the 4th; on 4 retries -> err=1, err_code=10, busy=0.
REQ-032 Scenario: m_err_i with m_ack_i in WR_PTR -> ERR, err_code=01, no done pulse; a new start clears err.
REQ-033 Scenario: reset asserted during POLL with stb=1 -> stb/cyc drop immediately, busy=0; cmd_start held at 1 across reset yields no transfer.
REQ-034 Scenario (JTAG_DMA_TIMEOUT_EN): status stuck busy -> err_code=11 after 1025 polls; without the macro, polling continues indefinitely.
